// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared beamformer output width and envelope-detector defaults
package bf_pkg;

   // Width of the delay-and-sum beamformer output sample
   localparam int BF_OUT_W       = 18;

   localparam int DEF_IN_W       = BF_OUT_W;
   localparam int DEF_OUT_W      = 8;
   localparam int DEF_WIN_LOG2   = 2;
   localparam int DEF_DECIM      = 2;
   localparam int DEF_LINE_LEN   = 256;
   localparam int DEF_FIFO_DEPTH = 4;

   // Counter width for a modulo-n counter; never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bf_pixel_fifo.sv
// rtl/bf_pixel_fifo.sv - show-ahead pixel FIFO that drops writes when full
module bf_pixel_fifo
   import bf_pkg::*;
#(
   parameter int DATA_W = DEF_OUT_W + 1,
   parameter int DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_ready,
   output logic              empty,
   output logic [DATA_W-1:0] rd_data,
   output logic              drop
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              full;
   logic              push;
   logic              pop;

   // Extra pointer bit distinguishes full from empty when the indices match
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop on the same edge frees the slot, so a full FIFO can still accept
   assign pop   = rd_ready && !empty;
   assign push  = wr_valid && (!full || pop);
   assign drop  = wr_valid && full && !pop;

   // Head is forced to zero when empty so stale entries never show
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update; reset discards every buffered entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write; contents are only visible through the gated head
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/bf_envelope_detect.sv
// rtl/bf_envelope_detect.sv - rectify, moving-average, decimate and buffer scan-line pixels
module bf_envelope_detect
   import bf_pkg::*;
#(
   parameter int IN_W       = DEF_IN_W,
   parameter int OUT_W      = DEF_OUT_W,
   parameter int WIN_LOG2   = DEF_WIN_LOG2,
   parameter int DECIM      = DEF_DECIM,
   parameter int LINE_LEN   = DEF_LINE_LEN,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_sol,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_pixel,
   output logic             out_last,
   output logic             overflow
);

   localparam int ABS_W        = IN_W - 1;
   localparam int WIN          = 1 << WIN_LOG2;
   localparam int SUM_W        = ABS_W + WIN_LOG2;
   localparam int PIX_PER_LINE = LINE_LEN / DECIM;
   localparam int DCNT_W       = cnt_w(DECIM);
   localparam int PCNT_W       = cnt_w(PIX_PER_LINE);

   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PIX_PER_LINE - 1);

   // Stage 1 state
   logic [IN_W-1:0]  neg_data;
   logic [ABS_W-1:0] abs_c;
   logic             s1_valid;
   logic [ABS_W-1:0] s1_abs;
   logic             s1_sol;
   logic             sol_pend;

   // Stage 2 state
   logic [ABS_W-1:0]  win_q    [WIN];
   logic [ABS_W-1:0]  win_base [WIN];
   logic [SUM_W-1:0]  sum_q;
   logic [SUM_W-1:0]  sum_base;
   logic [SUM_W-1:0]  sum_new;
   logic [DCNT_W-1:0] dcnt_q;
   logic [DCNT_W-1:0] dcnt_base;
   logic [PCNT_W-1:0] pcnt_q;
   logic [PCNT_W-1:0] pcnt_base;
   logic              emit;
   logic              line_end;
   logic              s2_valid;
   logic [OUT_W-1:0]  s2_pixel;
   logic              s2_last;

   // FIFO side
   logic             fifo_empty;
   logic [OUT_W:0]   fifo_head;
   logic             fifo_drop;

   // Rectify; the most negative input has no positive twin and saturates
   always_comb begin
      neg_data = ~in_data + IN_W'(1);
      if (!in_data[IN_W-1]) begin
         abs_c = in_data[ABS_W-1:0];
      end else if (in_data[ABS_W-1:0] == '0) begin
         abs_c = '1;
      end else begin
         abs_c = neg_data[ABS_W-1:0];
      end
   end

   // Stage 1 register; a start-of-line seen without a sample waits for the next one
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_abs   <= '0;
         s1_sol   <= 1'b0;
         sol_pend <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_abs   <= abs_c;
            s1_sol   <= in_sol || sol_pend;
            sol_pend <= 1'b0;
         end else if (in_sol) begin
            sol_pend <= 1'b1;
         end
      end
   end

   // Window/sum/counter view seen by the sample in stage 1, cleared when it starts a line
   always_comb begin
      for (int i = 0; i < WIN; i++) begin
         win_base[i] = s1_sol ? '0 : win_q[i];
      end
      sum_base  = s1_sol ? '0 : sum_q;
      dcnt_base = s1_sol ? '0 : dcnt_q;
      pcnt_base = s1_sol ? '0 : pcnt_q;
      sum_new   = sum_base + SUM_W'(s1_abs) - SUM_W'(win_base[WIN-1]);
      emit      = (dcnt_base == DCNT_LAST);
      line_end  = emit && (pcnt_base == PCNT_LAST);
   end

   // Stage 2: moving average, decimation and line tracking; pixel is the top OUT_W bits of the average
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WIN; i++) win_q[i] <= '0;
         sum_q    <= '0;
         dcnt_q   <= '0;
         pcnt_q   <= '0;
         s2_valid <= 1'b0;
         s2_pixel <= '0;
         s2_last  <= 1'b0;
      end else begin
         s2_valid <= s1_valid && emit;
         if (s1_valid) begin
            s2_pixel <= sum_new[SUM_W-1 -: OUT_W];
            s2_last  <= line_end;
            dcnt_q   <= emit ? '0 : dcnt_base + DCNT_W'(1);
            if (line_end) begin
               for (int i = 0; i < WIN; i++) win_q[i] <= '0;
               sum_q  <= '0;
               pcnt_q <= '0;
            end else begin
               win_q[0] <= s1_abs;
               for (int i = 1; i < WIN; i++) win_q[i] <= win_base[i-1];
               sum_q  <= sum_new;
               pcnt_q <= emit ? pcnt_base + PCNT_W'(1) : pcnt_base;
            end
         end
      end
   end

   bf_pixel_fifo #(
      .DATA_W (OUT_W + 1),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (s2_valid),
      .wr_data  ({s2_last, s2_pixel}),
      .rd_ready (out_ready),
      .empty    (fifo_empty),
      .rd_data  (fifo_head),
      .drop     (fifo_drop)
   );

   assign out_valid = !fifo_empty;
   assign out_last  = fifo_head[OUT_W];
   assign out_pixel = fifo_head[OUT_W-1:0];

   // Sticky drop flag; only reset clears it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (fifo_drop) begin
         overflow <= 1'b1;
      end
   end

endmodule
